// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: FSM state codes,
// the regfile forward-select value and the hard-wired zero register.
package pipe_hazard_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } hz_state_e;

    localparam int FWD_RF   = 0;
    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_scoreboard.sv
// In-flight destination scoreboard (EX..WB) with the per-source match and
// youngest-first priority encoder, shared by both ID source operands.
module hazard_scoreboard
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW     = 5,
    parameter int PIPE_DEPTH = 4,
    parameter int FORWARD_EN = 1,
    parameter int SEL_W      = $clog2(PIPE_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              advance,
    input  logic              ins_valid,
    input  logic [REG_AW-1:0] ins_rd,
    input  logic              ins_load,
    input  logic [REG_AW-1:0] rs,
    input  logic [REG_AW-1:0] rt,
    input  logic              rs_used,
    input  logic              rt_used,
    output logic              hazard,
    output logic [SEL_W-1:0]  fwd_a_sel,
    output logic [SEL_W-1:0]  fwd_b_sel
);

    logic [PIPE_DEPTH-1:0]             sb_vld;
    logic [PIPE_DEPTH-1:0]             sb_ld;
    logic [PIPE_DEPTH-1:0][REG_AW-1:0] sb_rd;

    logic [1:0][REG_AW-1:0]     src;
    logic [1:0]                 used;
    logic [1:0][PIPE_DEPTH-1:0] match;
    logic [1:0]                 haz;
    logic [1:0][SEL_W-1:0]      sel;

    assign src  = {rt, rs};
    assign used = {rt_used, rs_used};

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            sb_vld <= '0;
            sb_ld  <= '0;
            sb_rd  <= '0;
        end else if (advance) begin
            sb_vld <= {sb_vld[PIPE_DEPTH-2:0], ins_valid};
            sb_ld  <= {sb_ld[PIPE_DEPTH-2:0], ins_load};
            sb_rd  <= {sb_rd[PIPE_DEPTH-2:0], ins_rd};
        end
    end

    always_comb begin
        match = '0;
        for (int s = 0; s < 2; s++)
            for (int k = 0; k < PIPE_DEPTH; k++)
                match[s][k] = used[s] && sb_vld[k] && (sb_rd[k] == src[s]) &&
                              (src[s] != REG_AW'(REG_ZERO));
    end

    // Oldest-to-youngest scan so the youngest producer wins; the WB stage is
    // never forwarded because the regfile write lands before the ID read.
    always_comb begin
        haz = '0;
        sel = '0;
        for (int s = 0; s < 2; s++) begin
            sel[s] = SEL_W'(FWD_RF);
            if (FORWARD_EN != 0) begin
                if (match[s][0] && sb_ld[0])
                    haz[s] = 1'b1;
                else
                    for (int k = PIPE_DEPTH-2; k >= 0; k--)
                        if (match[s][k]) sel[s] = SEL_W'(k + 1);
            end else begin
                for (int k = 0; k < PIPE_DEPTH-1; k++)
                    if (match[s][k]) haz[s] = 1'b1;
            end
        end
    end

    assign hazard    = |haz;
    assign fwd_a_sel = sel[0];
    assign fwd_b_sel = sel[1];

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard/interlock controller: branch-flush FSM, freeze/flush/stall
// priority, and a saturating stall-cycle counter around the scoreboard.
module pipe_hazard_ctrl
    import pipe_hazard_ctrl_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int PIPE_DEPTH   = 4,
    parameter int FORWARD_EN   = 1,
    parameter int BRANCH_FLUSH = 2,
    parameter int CNT_W        = 16
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          id_valid,
    input  logic [REG_AW-1:0]             id_rs,
    input  logic [REG_AW-1:0]             id_rt,
    input  logic                          id_rs_used,
    input  logic                          id_rt_used,
    input  logic                          id_regwr,
    input  logic [REG_AW-1:0]             id_rd,
    input  logic                          id_memtoreg,
    input  logic                          ex_br_taken,
    input  logic                          mem_busy,
    output logic                          stall_if,
    output logic                          stall_id,
    output logic                          flush_ifid,
    output logic [$clog2(PIPE_DEPTH)-1:0] fwd_a_sel,
    output logic [$clog2(PIPE_DEPTH)-1:0] fwd_b_sel,
    output logic [CNT_W-1:0]              stall_cnt
);

    localparam int SEL_W = $clog2(PIPE_DEPTH);

    hz_state_e  state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;
    logic       hazard, branch, ins_valid;

    assign branch    = ex_br_taken || (state == ST_FLUSH);
    assign ins_valid = !branch && !hazard && id_valid && id_regwr;

    hazard_scoreboard #(
        .REG_AW     (REG_AW),
        .PIPE_DEPTH (PIPE_DEPTH),
        .FORWARD_EN (FORWARD_EN),
        .SEL_W      (SEL_W)
    ) u_sb (
        .clk       (clk),
        .rst       (rst),
        .advance   (!mem_busy),
        .ins_valid (ins_valid),
        .ins_rd    (id_rd),
        .ins_load  (id_memtoreg),
        .rs        (id_rs),
        .rt        (id_rt),
        .rs_used   (id_rs_used),
        .rt_used   (id_rt_used),
        .hazard    (hazard),
        .fwd_a_sel (fwd_a_sel),
        .fwd_b_sel (fwd_b_sel)
    );

    // Freeze beats flush beats hazard; outputs are forced quiet while in reset.
    always_comb begin
        stall_if   = 1'b0;
        stall_id   = 1'b0;
        flush_ifid = 1'b0;
        if (!rst) begin
            if (mem_busy) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end else if (branch) begin
                flush_ifid = 1'b1;
            end else if (hazard) begin
                stall_if = 1'b1;
                stall_id = 1'b1;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        if (!mem_busy) begin
            if (ex_br_taken && (BRANCH_FLUSH > 1)) begin
                state_nxt = ST_FLUSH;
                fcnt_nxt  = 3'(BRANCH_FLUSH - 1);
            end else if (state == ST_FLUSH) begin
                if (fcnt <= 3'd1) begin
                    state_nxt = ST_RUN;
                    fcnt_nxt  = '0;
                end else begin
                    fcnt_nxt = fcnt - 3'd1;
                end
            end
        end
    end

    always_ff @(negedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_RUN;
            fcnt      <= '0;
            stall_cnt <= '0;
        end else begin
            state <= state_nxt;
            fcnt  <= fcnt_nxt;
            if (stall_if && (stall_cnt != '1))
                stall_cnt <= stall_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: a forwarding/16-bit-counter instance and an
// interlock-only/4-bit-counter instance share stimulus and a reference model.
module tb_pipe_hazard_ctrl;

    localparam int D  = 4;
    localparam int BF = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       id_valid, id_rs_used, id_rt_used, id_regwr, id_memtoreg;
    logic [4:0] id_rs, id_rt, id_rd;
    logic       ex_br_taken, mem_busy;

    logic [1:0]  si, sd, fl;
    logic [1:0]  sa0, sb0, sa1, sb1;
    logic [15:0] sc0;
    logic [3:0]  sc1;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.REG_AW(5), .PIPE_DEPTH(D), .FORWARD_EN(1), .BRANCH_FLUSH(BF), .CNT_W(16)) dut0 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwr(id_regwr), .id_rd(id_rd),
        .id_memtoreg(id_memtoreg), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .stall_if(si[0]), .stall_id(sd[0]), .flush_ifid(fl[0]),
        .fwd_a_sel(sa0), .fwd_b_sel(sb0), .stall_cnt(sc0));

    pipe_hazard_ctrl #(.REG_AW(5), .PIPE_DEPTH(D), .FORWARD_EN(0), .BRANCH_FLUSH(BF), .CNT_W(4)) dut1 (
        .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_rs_used(id_rs_used), .id_rt_used(id_rt_used), .id_regwr(id_regwr), .id_rd(id_rd),
        .id_memtoreg(id_memtoreg), .ex_br_taken(ex_br_taken), .mem_busy(mem_busy),
        .stall_if(si[1]), .stall_id(sd[1]), .flush_ifid(fl[1]),
        .fwd_a_sel(sa1), .fwd_b_sel(sb1), .stall_cnt(sc1));

    // Reference model: list of in-flight producers, youngest first.
    bit m_v [2][D];
    int m_rd[2][D];
    bit m_ld[2][D];
    int m_rem[2];
    int m_cnt[2];
    int fe[2]   = '{1, 0};
    int cmax[2] = '{65535, 15};

    task automatic chk(input string nm, input int act, input int exp);
        ntests++;
        if (act != exp) begin
            nfail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    function automatic int youngest(input int i, input int r);
        for (int k = 0; k < D; k++)
            if (m_v[i][k] && m_rd[i][k] == r) return k;
        return -1;
    endfunction

    always @(posedge clk) begin
        int  ka, kb, e_sa, e_sb;
        bit  haz, br, e_si, e_fl, ins;
        #2;
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                for (int k = 0; k < D; k++) m_v[i][k] = 0;
                m_rem[i] = 0;
                m_cnt[i] = 0;
            end
            ka = (id_rs_used && id_rs != 0) ? youngest(i, int'(id_rs)) : -1;
            kb = (id_rt_used && id_rt != 0) ? youngest(i, int'(id_rt)) : -1;
            haz = 0; e_sa = 0; e_sb = 0;
            if (fe[i] != 0) begin
                if (ka == 0 && m_ld[i][0]) haz = 1;
                else if (ka >= 0 && ka < D-1) e_sa = ka + 1;
                if (kb == 0 && m_ld[i][0]) haz = 1;
                else if (kb >= 0 && kb < D-1) e_sb = kb + 1;
            end else begin
                haz = (ka >= 0 && ka < D-1) || (kb >= 0 && kb < D-1);
            end
            br   = ex_br_taken || m_rem[i] > 0;
            e_si = !rst && (mem_busy || (!br && haz));
            e_fl = !rst && !mem_busy && br;
            chk($sformatf("dut%0d stall_if", i),   int'(si[i]), int'(e_si));
            chk($sformatf("dut%0d stall_id", i),   int'(sd[i]), int'(e_si));
            chk($sformatf("dut%0d flush_ifid", i), int'(fl[i]), int'(e_fl));
            chk($sformatf("dut%0d fwd_a_sel", i),  (i == 0) ? int'(sa0) : int'(sa1), e_sa);
            chk($sformatf("dut%0d fwd_b_sel", i),  (i == 0) ? int'(sb0) : int'(sb1), e_sb);
            chk($sformatf("dut%0d stall_cnt", i),  (i == 0) ? int'(sc0) : int'(sc1), m_cnt[i]);
            if (!rst) begin
                if (e_si && m_cnt[i] < cmax[i]) m_cnt[i]++;
                if (!mem_busy) begin
                    ins = !br && !haz && id_valid && id_regwr;
                    for (int k = D-1; k > 0; k--) begin
                        m_v[i][k]  = m_v[i][k-1];
                        m_rd[i][k] = m_rd[i][k-1];
                        m_ld[i][k] = m_ld[i][k-1];
                    end
                    m_v[i][0]  = ins;
                    m_rd[i][0] = int'(id_rd);
                    m_ld[i][0] = id_memtoreg;
                    m_rem[i]   = ex_br_taken ? BF-1 : (m_rem[i] > 0 ? m_rem[i]-1 : 0);
                end
            end
        end
    end

    // One clock: drive at posedge, leave 3 time units for outputs to settle.
    task automatic cyc(input bit r, input bit v, input int rs, input int rt,
                       input bit ru, input bit tu, input bit wr, input int rd,
                       input bit ld, input bit br, input bit busy);
        @(posedge clk);
        rst = r; id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt);
        id_rs_used = ru; id_rt_used = tu; id_regwr = wr; id_rd = 5'(rd);
        id_memtoreg = ld; ex_br_taken = br; mem_busy = busy;
        #3;
    endtask

    task automatic drain(input int n);
        repeat (n) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        id_valid = 0; id_rs = 0; id_rt = 0; id_rs_used = 0; id_rt_used = 0;
        id_regwr = 0; id_rd = 0; id_memtoreg = 0; ex_br_taken = 0; mem_busy = 0;
        repeat (2) cyc(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("reset stall_cnt", int'(sc0), 0);

        // ALU RAW: add r3 ; sub r4 <- r3
        cyc(0, 1, 0, 0, 0, 0, 1, 3, 0, 0, 0);
        cyc(0, 1, 3, 0, 1, 0, 1, 4, 0, 0, 0);
        chk("raw fwd sel", int'(sa0), 1);
        chk("raw fwd no stall", int'(si[0]), 0);
        chk("raw interlock stall 1", int'(si[1]), 1);
        cyc(0, 1, 3, 0, 1, 0, 1, 4, 0, 0, 0);
        chk("raw interlock stall 2", int'(si[1]), 1);
        cyc(0, 1, 3, 0, 1, 0, 1, 4, 0, 0, 0);
        chk("raw interlock stall 3", int'(si[1]), 1);
        cyc(0, 1, 3, 0, 1, 0, 1, 4, 0, 0, 0);
        chk("raw interlock release", int'(si[1]), 0);
        drain(5);

        // Load-use: lw r5 ; add r6 <- r5
        cyc(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        cyc(0, 1, 5, 0, 1, 0, 1, 6, 0, 0, 0);
        chk("load-use stall", int'(si[0]), 1);
        cyc(0, 1, 5, 0, 1, 0, 1, 6, 0, 0, 0);
        chk("load-use resume", int'(si[0]), 0);
        chk("load-use fwd sel", int'(sa0), 2);
        chk("load-use stall_cnt", int'(sc0), 1);
        drain(5);

        // r0 is never a hazard
        cyc(0, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0);
        cyc(0, 1, 0, 0, 1, 1, 1, 7, 0, 0, 0);
        chk("r0 fwd stall", int'(si[0]), 0);
        chk("r0 interlock stall", int'(si[1]), 0);
        chk("r0 sel a", int'(sa0), 0);
        drain(5);

        // Taken branch together with a load-use
        cyc(0, 1, 0, 0, 0, 0, 1, 5, 1, 0, 0);
        cyc(0, 1, 5, 0, 1, 0, 1, 6, 0, 1, 0);
        chk("branch flush 1", int'(fl[0]), 1);
        chk("branch no stall 1", int'(si[0]), 0);
        cyc(0, 1, 5, 0, 1, 0, 1, 6, 0, 0, 0);
        chk("branch flush 2", int'(fl[0]), 1);
        chk("branch no stall 2", int'(si[0]), 0);
        cyc(0, 1, 5, 0, 1, 0, 1, 6, 0, 0, 0);
        chk("branch flush done", int'(fl[0]), 0);
        chk("branch lw at stage 2", int'(sa0), 3);
        drain(5);

        // mem_busy during a load-use
        cyc(0, 1, 0, 0, 0, 0, 1, 6, 1, 0, 0);
        repeat (3) begin
            cyc(0, 1, 6, 0, 1, 0, 1, 7, 0, 0, 1);
            chk("busy freeze stall", int'(si[0]), 1);
        end
        cyc(0, 1, 6, 0, 1, 0, 1, 7, 0, 0, 0);
        chk("busy then load-use stall", int'(si[0]), 1);
        cyc(0, 1, 6, 0, 1, 0, 1, 7, 0, 0, 0);
        chk("busy resume sel", int'(sa0), 2);
        chk("busy stall_cnt", int'(sc0), 5);
        drain(5);

        // Saturation of the 4-bit counter
        repeat (20) cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        chk("sat stall_cnt 4b", int'(sc1), 15);
        chk("sat stall_cnt 16b", int'(sc0), 25);

        // Reset mid-stream clears the in-flight load
        cyc(0, 1, 0, 0, 0, 0, 1, 7, 1, 0, 0);
        cyc(1, 1, 7, 0, 1, 0, 1, 8, 0, 0, 0);
        chk("rst stall_if", int'(si[0]), 0);
        chk("rst stall_cnt", int'(sc0), 0);
        cyc(0, 1, 7, 0, 1, 0, 1, 8, 0, 0, 0);
        chk("post-rst no stall", int'(si[0]), 0);
        chk("post-rst sel", int'(sa0), 0);

        // Randomised traffic on a small register set to provoke hazards
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 3) != 0),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
                ($urandom_range(0, 3) != 0), int'($urandom_range(0, 3)),
                ($urandom_range(0, 2) == 0), ($urandom_range(0, 9) == 0),
                ($urandom_range(0, 7) == 0));
        end
        drain(2);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
